tm1638_responder: RTL and testbench
===================================

Name: tm1638_responder

Overview:
Device-side (responder) model of the TM1638 three-wire serial link. It receives command and data bytes from a strobe/clock/dio initiator, keeps the 16-byte display RAM and the display-control register, and returns four key-scan bytes on read commands. It emulates an LED&KEY board inside the FPGA, for board-to-board links and for closed-loop benches of the initiator.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each of tm_strobe, tm_clock and tm_dio_in before use (minimum 2).

Ports:
clock  input  1  master clock; the only clock in the block.
reset  input  1  asynchronous, active-low reset.
tm_strobe  input  1  frame select from the initiator, active low.
tm_clock  input  1  serial clock from the initiator.
tm_dio_in  input  1  data pin value as received (pad input).
tm_dio_out  output  1  data value driven during reads.
tm_dio_oe  output  1  pad output enable; 1 means the responder drives the pin.
keys  input  8  live key states, 1 = pressed.
display0..display7  output  8 each  segment bytes.
leds  output  8  LED states.
display_on  output  1  display-control bit 3.
brightness  output  3  display-control bits 2:0.
update  output  1  one-cycle pulse at the end of a frame that wrote RAM.

Behaviour:
- Reset (reset=0, asynchronous) sets the following, and all of them stay held while reset is low:
  - All RAM to 0: display0..7=0, leds=0.
  - display_on=0, brightness=0, update=0, tm_dio_oe=0, tm_dio_out=1.
  - Mode=write, auto-increment, address 0.
  - State=IDLE.
- Input handling:
  - Inputs pass through SYNC_STAGES flip-flops, then go to a registered edge detector.
  - All timing below refers to these synchronized edges.
  - Each tm_clock phase must last at least SYNC_STAGES+3 clock cycles.
- Bit order and sampling:
  - Bits are LSB first.
  - tm_dio_in is sampled on each tm_clock rising edge.
  - A bit counter (0..7) tracks the current byte. It is cleared on tm_strobe falling.
- Mode rules:
  - The first byte after tm_strobe falls is the command. Later bytes in the same frame are data.
  - Data command 0x40-0x4F: bit1=1 selects read, bit1=0 selects write; bit2=1 selects fixed address, bit2=0 selects auto-increment. The mode persists across frames.
  - Display control 0x80-0x8F: display_on=cmd[3], brightness=cmd[2:0]. Following bytes in the frame are ignored.
  - Address set 0xC0-0xCF: address=cmd[3:0]. Following bytes are written to RAM when the mode is write.
  - In auto-increment mode the address increments by 1 after each byte and wraps from 15 to 0. In fixed mode the address holds.
  - Any other command byte goes to IGNORE.
- States:
  - IDLE: entered when tm_strobe is high. Falling tm_strobe moves to CMD.
  - CMD: on byte 8 of the command, go to WRITE_DATA (0xC0-0xCF, write mode), READ_DATA (data command with read bit, e.g. 0x42), or IGNORE (all other cases).
  - WRITE_DATA: each complete byte is written to RAM[address].
  - READ_DATA: returns 4 bytes, then goes to IGNORE.
  - IGNORE: discards all bytes until tm_strobe rises.
- A tm_strobe rise in any state returns to IDLE. A partial byte (fewer than 8 bits) is discarded with no RAM or register side effects.
- RAM mapping:
  - Address 2k maps to display(7-k).
  - Address 2k+1 bit0 maps to leds[7-k]. Bits 7:1 of odd addresses are stored but not output.
- Write timing: RAM and control outputs update exactly 1 cycle after the detected 8th rising edge.
- update pulses high for exactly 1 cycle, 1 cycle after tm_strobe is detected rising, and only if at least one RAM byte was written in that frame.
- Read sequence:
  - keys is latched at the 8th rising edge of the read command byte.
  - Read byte k (k=0..3): bit0=keys[7-k], bit4=keys[3-k], all other bits 0.
  - tm_dio_oe asserts on the tm_clock falling edge after the command byte. tm_dio_out presents bit 0 at the same time.
  - Each later tm_clock falling edge advances one bit, so a bit is stable through the following high phase.
  - After 32 bits, tm_dio_oe drops on the next falling edge. tm_strobe rising also drops it immediately (within 1 cycle).
  - tm_dio_out is 1 whenever tm_dio_oe=0.
- A tm_strobe fall while already in a frame (no rise detected first) is not possible after synchronization. A tm_clock edge while tm_strobe is high is ignored.
- Reset mid-frame: reset dominates and everything returns to reset values. The next frame needs a fresh tm_strobe fall.

Test Plan:
- Reset: drive reset low mid-frame, release, then drive 5 tm_clock pulses. Required: display0..7=0, leds=0, display_on=0, tm_dio_oe=0, no update pulse.
- Display control: frame 0x8F gives display_on=1, brightness=7. Frame 0x8A gives display_on=1, brightness=2. Frame 0x80 gives display_on=0.
- Auto-increment write: frame 0x40, then frame 0xC0 followed by 16 bytes alternating 0x3F,0x01. Required: display0..7=0x3F, leds=0xFF, exactly one update pulse.
- Fixed address and wrap:
  - Frame 0x44, then frame 0xCE,0x55,0xAA: display0=0xAA and address 15 is unchanged.
  - Then frame 0x40 and frame 0xCF,0x01,0x77: leds[0]=1, display7=0x77.
- Key read: keys=8'b1000_0001, frame 0x42 plus 32 clocks. Required bytes 0x01,0x00,0x00,0x10 LSB first. tm_dio_oe=1 only during those bits, then 0 after tm_strobe rises.
- Abort: frame 0xC0 then 0x5A with tm_strobe rising after 5 data bits. Required: RAM unchanged, no update pulse. A following full frame 0xC0,0x5A sets display7=0x5A.

Source files
------------

// File: rtl/tm1638_responder_if.sv
// TM1638 three-wire link: strobe/clock/dio from the initiator, dio drive back from the responder.
interface tm1638_responder_if;
    logic tm_strobe;
    logic tm_clock;
    logic tm_dio_in;
    logic tm_dio_out;
    logic tm_dio_oe;

    modport master (
        output tm_strobe,
        output tm_clock,
        output tm_dio_in,
        input  tm_dio_out,
        input  tm_dio_oe
    );

    modport slave (
        input  tm_strobe,
        input  tm_clock,
        input  tm_dio_in,
        output tm_dio_out,
        output tm_dio_oe
    );
endinterface

// File: rtl/tm1638_responder.sv
// TM1638 responder: decodes initiator frames into a 16-byte display RAM and
// control register, and shifts four key-scan bytes back on read commands.
module tm1638_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    tm1638_responder_if.slave    tm,
    input  logic [7:0]           keys,
    output logic [7:0]           display0,
    output logic [7:0]           display1,
    output logic [7:0]           display2,
    output logic [7:0]           display3,
    output logic [7:0]           display4,
    output logic [7:0]           display5,
    output logic [7:0]           display6,
    output logic [7:0]           display7,
    output logic [7:0]           leds,
    output logic                 display_on,
    output logic [2:0]           brightness,
    output logic                 update
);

    localparam int unsigned RAM_DEPTH = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned RD_BITS   = 32;
    localparam int unsigned RD_CNT_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ,
        ST_IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
    logic                   stb_prev_q, stb_prev_d;
    logic                   clk_prev_q, clk_prev_d;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]      shift_q, shift_d;
    logic                   mode_read_q, mode_read_d;
    logic                   mode_fixed_q, mode_fixed_d;
    logic [3:0]             addr_q, addr_d;
    logic [BYTE_W-1:0]      ram_q [RAM_DEPTH];
    logic [BYTE_W-1:0]      ram_d [RAM_DEPTH];
    logic                   on_q, on_d;
    logic [2:0]             bright_q, bright_d;
    logic                   update_q, update_d;
    logic                   wrote_q, wrote_d;
    logic                   oe_q, oe_d;
    logic                   dout_q, dout_d;
    logic [RD_CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [RD_BITS-1:0]     rd_data_q, rd_data_d;

    logic                   stb_s, clk_s, dio_s;
    logic                   stb_rise_c, stb_fall_c, clk_rise_c, clk_fall_c;
    logic [BYTE_W-1:0]      byte_c;
    logic [RD_BITS-1:0]     key_word_c;

    assign stb_s      = stb_sync_q[SYNC_STAGES-1];
    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign dio_s      = dio_sync_q[SYNC_STAGES-1];
    assign stb_rise_c = stb_s & ~stb_prev_q;
    assign stb_fall_c = ~stb_s & stb_prev_q;
    assign clk_rise_c = clk_s & ~clk_prev_q;
    assign clk_fall_c = ~clk_s & clk_prev_q;
    // LSB-first shift: the 8th sampled bit lands in bit 7.
    assign byte_c     = {dio_s, shift_q[BYTE_W-1:1]};

    // Key-scan byte k: bit0 = keys[7-k], bit4 = keys[3-k].
    always_comb begin
        key_word_c = '0;
        for (int k = 0; k < 4; k++) begin
            key_word_c[8*k]     = keys[7-k];
            key_word_c[8*k + 4] = keys[3-k];
        end
    end

    always_comb begin
        stb_sync_d   = {stb_sync_q[SYNC_STAGES-2:0], tm.tm_strobe};
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], tm.tm_clock};
        dio_sync_d   = {dio_sync_q[SYNC_STAGES-2:0], tm.tm_dio_in};
        stb_prev_d   = stb_s;
        clk_prev_d   = clk_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        mode_read_d  = mode_read_q;
        mode_fixed_d = mode_fixed_q;
        addr_d       = addr_q;
        ram_d        = ram_q;
        on_d         = on_q;
        bright_d     = bright_q;
        update_d     = 1'b0;
        wrote_d      = wrote_q;
        oe_d         = oe_q;
        dout_d       = dout_q;
        rd_cnt_d     = rd_cnt_q;
        rd_data_d    = rd_data_q;

        if (state_q != ST_IDLE && stb_rise_c) begin
            // End of frame: release the pin and flag RAM writes, partial byte dropped.
            state_d  = ST_IDLE;
            oe_d     = 1'b0;
            dout_d   = 1'b1;
            update_d = wrote_q;
            wrote_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stb_fall_c) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                        wrote_d   = 1'b0;
                    end
                end
                ST_CMD, ST_WRITE, ST_IGNORE: begin
                    if (clk_rise_c) begin
                        shift_d   = byte_c;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7 && state_q == ST_CMD) begin
                            state_d = ST_IGNORE;
                            case (byte_c[7:4])
                                4'h4: begin
                                    mode_read_d  = byte_c[1];
                                    mode_fixed_d = byte_c[2];
                                    if (byte_c[1]) begin
                                        state_d   = ST_READ;
                                        rd_data_d = key_word_c;
                                        rd_cnt_d  = '0;
                                    end
                                end
                                4'h8: begin
                                    on_d     = byte_c[3];
                                    bright_d = byte_c[2:0];
                                end
                                4'hC: begin
                                    addr_d = byte_c[3:0];
                                    if (!mode_read_q) begin
                                        state_d = ST_WRITE;
                                    end
                                end
                                default: state_d = ST_IGNORE;
                            endcase
                        end else if (bit_cnt_q == 3'd7 && state_q == ST_WRITE) begin
                            ram_d[addr_q] = byte_c;
                            wrote_d       = 1'b1;
                            if (!mode_fixed_q) begin
                                addr_d = addr_q + 4'd1;
                            end
                        end
                    end
                end
                ST_READ: begin
                    // Each falling edge presents the next bit; one past the last releases the pin.
                    if (clk_fall_c) begin
                        if (rd_cnt_q == RD_CNT_W'(RD_BITS)) begin
                            oe_d    = 1'b0;
                            dout_d  = 1'b1;
                            state_d = ST_IGNORE;
                        end else begin
                            oe_d     = 1'b1;
                            dout_d   = rd_data_q[rd_cnt_q[4:0]];
                            rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // Strobe chain resets low so a strobe already low at release never opens a frame.
            stb_sync_q   <= '0;
            clk_sync_q   <= '0;
            dio_sync_q   <= '1;
            stb_prev_q   <= 1'b0;
            clk_prev_q   <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= '0;
            mode_read_q  <= 1'b0;
            mode_fixed_q <= 1'b0;
            addr_q       <= 4'd0;
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram_q[i] <= '0;
            end
            on_q         <= 1'b0;
            bright_q     <= 3'd0;
            update_q     <= 1'b0;
            wrote_q      <= 1'b0;
            oe_q         <= 1'b0;
            dout_q       <= 1'b1;
            rd_cnt_q     <= '0;
            rd_data_q    <= '0;
        end else begin
            stb_sync_q   <= stb_sync_d;
            clk_sync_q   <= clk_sync_d;
            dio_sync_q   <= dio_sync_d;
            stb_prev_q   <= stb_prev_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            mode_read_q  <= mode_read_d;
            mode_fixed_q <= mode_fixed_d;
            addr_q       <= addr_d;
            ram_q        <= ram_d;
            on_q         <= on_d;
            bright_q     <= bright_d;
            update_q     <= update_d;
            wrote_q      <= wrote_d;
            oe_q         <= oe_d;
            dout_q       <= dout_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Even addresses feed the digits in reverse order; odd-address bit0 feeds the LEDs.
    always_comb begin
        leds = '0;
        for (int k = 0; k < 8; k++) begin
            leds[7-k] = ram_q[2*k + 1][0];
        end
    end

    assign display0      = ram_q[14];
    assign display1      = ram_q[12];
    assign display2      = ram_q[10];
    assign display3      = ram_q[8];
    assign display4      = ram_q[6];
    assign display5      = ram_q[4];
    assign display6      = ram_q[2];
    assign display7      = ram_q[0];
    assign display_on    = on_q;
    assign brightness    = bright_q;
    assign update        = update_q;
    assign tm.tm_dio_oe  = oe_q;
    assign tm.tm_dio_out = dout_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: frame-level reference model plus a read-bit scoreboard.
module tb_tm1638_responder;

    localparam int unsigned SYNC = 2;
    localparam int PH = SYNC + 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] keys;
    logic [7:0] display0, display1, display2, display3;
    logic [7:0] display4, display5, display6, display7;
    logic [7:0] leds;
    logic       display_on;
    logic [2:0] brightness;
    logic       update;
    logic [7:0] disp [8];

    tm1638_responder_if tm_if ();

    tm1638_responder #(.SYNC_STAGES(SYNC)) dut (
        .clock      (clock),
        .reset      (reset),
        .tm         (tm_if.slave),
        .keys       (keys),
        .display0   (display0),
        .display1   (display1),
        .display2   (display2),
        .display3   (display3),
        .display4   (display4),
        .display5   (display5),
        .display6   (display6),
        .display7   (display7),
        .leds       (leds),
        .display_on (display_on),
        .brightness (brightness),
        .update     (update)
    );

    always #5 clock = ~clock;

    assign disp[0] = display0;
    assign disp[1] = display1;
    assign disp[2] = display2;
    assign disp[3] = display3;
    assign disp[4] = display4;
    assign disp[5] = display5;
    assign disp[6] = display6;
    assign disp[7] = display7;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [7:0] m_ram [16];
    bit         m_on;
    logic [2:0] m_br;
    bit         m_read;
    bit         m_fixed;
    logic [3:0] m_addr;
    bit         sb [$];

    // Frame descriptor consumed by do_frame
    logic [7:0] fb [$];
    int         fpart;
    logic [7:0] fpat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        tm_if.tm_clock  = 1'b0;
        tm_if.tm_dio_in = b;
        tick(PH);
        tm_if.tm_clock  = 1'b1;
        tick(PH);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int b = 0; b < 8; b++) send_bit(v[b]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_on = 1'b0; m_br = 3'd0; m_read = 1'b0; m_fixed = 1'b0; m_addr = 4'd0;
    endtask

    task automatic check_outputs(input string tag);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("%s display%0d", tag, j), 32'(disp[j]), 32'(m_ram[2*(7-j)]));
            chk($sformatf("%s leds[%0d]", tag, j), 32'(leds[j]), 32'(m_ram[2*(7-j)+1][0]));
        end
        chk({tag, " display_on"}, 32'(display_on), 32'(m_on));
        chk({tag, " brightness"}, 32'(brightness), 32'(m_br));
        chk({tag, " dio_oe"}, 32'(tm_if.tm_dio_oe), 32'd0);
        chk({tag, " dio_out"}, 32'(tm_if.tm_dio_out), 32'd1);
    endtask

    // Drive one frame from fb/fpart/fpat and advance the model by the same rules.
    task automatic do_frame(input string tag);
        int         upd0;
        bit         wrote;
        logic [7:0] cmd;
        logic [7:0] rb;
        upd0  = upd_cnt;
        wrote = 1'b0;
        cmd   = fb[0];
        tm_if.tm_strobe = 1'b0;
        tick(PH);
        send_byte(cmd);
        if (cmd[7:4] == 4'h4) begin
            m_read  = cmd[1];
            m_fixed = cmd[2];
        end else if (cmd[7:4] == 4'h8) begin
            m_on = cmd[3];
            m_br = cmd[2:0];
        end else if (cmd[7:4] == 4'hC) begin
            m_addr = cmd[3:0];
        end
        if (cmd[7:4] == 4'h4 && cmd[1]) begin
            for (int k = 0; k < 4; k++) begin
                rb = 8'h00;
                rb[0] = keys[7-k];
                rb[4] = keys[3-k];
                for (int b = 0; b < 8; b++) sb.push_back(rb[b]);
            end
            for (int i = 0; i < 32; i++) send_bit(1'b1);
        end else begin
            for (int i = 1; i < fb.size(); i++) begin
                send_byte(fb[i]);
                if (cmd[7:4] == 4'hC && !m_read) begin
                    m_ram[m_addr] = fb[i];
                    wrote = 1'b1;
                    if (!m_fixed) m_addr = m_addr + 4'd1;
                end
            end
            for (int b = 0; b < fpart; b++) send_bit(fpat[b]);
        end
        tm_if.tm_strobe = 1'b1;
        tick(PH + 4);
        chk({tag, " update_pulses"}, 32'(upd_cnt - upd0), 32'(wrote));
        chk({tag, " read_bits_left"}, 32'(sb.size()), 32'd0);
        check_outputs(tag);
    endtask

    task automatic frame1(input logic [7:0] c, input string tag);
        fb = {c}; fpart = 0;
        do_frame(tag);
    endtask

    always @(posedge clock) if (update) upd_cnt++;

    // Scoreboard monitor: at every initiator rising edge inside a frame, the pin must
    // carry the next expected read bit, or be released when none is pending.
    always @(posedge tm_if.tm_clock) begin
        if (mon_en && !tm_if.tm_strobe) begin
            if (sb.size() > 0) begin
                logic eb;
                eb = sb.pop_front();
                chk("read dio_oe", 32'(tm_if.tm_dio_oe), 32'd1);
                chk("read dio_out", 32'(tm_if.tm_dio_out), 32'(eb));
            end else begin
                chk("idle dio_oe", 32'(tm_if.tm_dio_oe), 32'd0);
            end
        end
    end

    initial begin
        int upd0;
        int r;
        logic [7:0] c;
        reset = 1'b0;
        keys  = 8'h00;
        tm_if.tm_strobe = 1'b1;
        tm_if.tm_clock  = 1'b1;
        tm_if.tm_dio_in = 1'b1;
        fpart = 0; fpat = 8'h00;
        model_reset();
        tick(5);
        reset = 1'b1;
        tick(5);
        mon_en = 1'b1;
        check_outputs("reset");
        chk("reset update", 32'(upd_cnt), 32'd0);

        frame1(8'h8F, "ctrl8F");
        chk("ctrl8F on", 32'(display_on), 32'd1);
        chk("ctrl8F bright", 32'(brightness), 32'd7);
        frame1(8'h8A, "ctrl8A");
        chk("ctrl8A bright", 32'(brightness), 32'd2);
        frame1(8'h80, "ctrl80");
        chk("ctrl80 on", 32'(display_on), 32'd0);

        frame1(8'h40, "mode40");
        fb = {8'hC0}; fpart = 0;
        for (int i = 0; i < 8; i++) begin fb.push_back(8'h3F); fb.push_back(8'h01); end
        do_frame("autoinc");
        chk("autoinc leds", 32'(leds), 32'hFF);
        chk("autoinc display3", 32'(display3), 32'h3F);

        frame1(8'h44, "mode44");
        fb = {8'hCE, 8'h55, 8'hAA}; fpart = 0;
        do_frame("fixed");
        chk("fixed display0", 32'(display0), 32'hAA);
        chk("fixed leds0", 32'(leds[0]), 32'd1);
        frame1(8'h40, "mode40b");
        fb = {8'hCF, 8'h01, 8'h77}; fpart = 0;
        do_frame("wrap");
        chk("wrap display7", 32'(display7), 32'h77);

        keys = 8'b1000_0001;
        frame1(8'h42, "keyread");

        frame1(8'h40, "mode40c");
        fb = {8'hC0}; fpart = 5; fpat = 8'h5A;
        do_frame("abort");
        fb = {8'hC0, 8'h5A}; fpart = 0;
        do_frame("after_abort");
        chk("after_abort display7", 32'(display7), 32'h5A);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 3));
            fpart = int'($urandom_range(0, 7));
            fpat  = 8'($urandom);
            c     = 8'($urandom);
            case (r)
                0: begin
                    c = {4'h4, c[3:0]};
                    if (c[1]) keys = 8'($urandom);
                    fb = {c};
                    if (!c[1]) repeat ($urandom_range(0, 2)) fb.push_back(8'($urandom));
                end
                1: begin
                    fb = {8'h80 | {4'h0, c[3:0]}};
                    repeat ($urandom_range(0, 2)) fb.push_back(8'($urandom));
                end
                2: begin
                    fb = {8'hC0 | {4'h0, c[3:0]}};
                    repeat ($urandom_range(0, 5)) fb.push_back(8'($urandom));
                end
                default: begin
                    if (c[7:4] == 4'h4 || c[7:4] == 4'h8 || c[7:4] == 4'hC) c[7] = ~c[7];
                    if (c[7:4] == 4'h4 || c[7:4] == 4'h8 || c[7:4] == 4'hC) c[4] = ~c[4];
                    fb = {c};
                    repeat ($urandom_range(0, 2)) fb.push_back(8'($urandom));
                end
            endcase
            do_frame($sformatf("rand%0d", n));
        end

        // Reset in the middle of a write frame, then clock pulses with strobe still low.
        frame1(8'h40, "mode40d");
        upd0 = upd_cnt;
        tm_if.tm_strobe = 1'b0;
        tick(PH);
        send_byte(8'hC0);
        send_byte(8'hFF);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        model_reset();
        tick(3);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        tick(4);
        check_outputs("midreset");
        tm_if.tm_strobe = 1'b1;
        tick(PH + 4);
        chk("midreset update", 32'(upd_cnt - upd0), 32'd0);
        check_outputs("midreset_rise");

        fb = {8'hC3, 8'hC3}; fpart = 0;
        do_frame("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
